// File: rtl/uart_pkg.sv
// Shared types for the FIFO-draining UART transmitter.
// FSM state encoding and parity mode selectors.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

endpackage

// File: rtl/baud_counter.sv
// Bit-period timer for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module baud_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    assign bit_done = (r_cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear || bit_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side drain: pops one word per frame and serializes it
// as start bit, LSB-first data, optional parity, stop bit.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_read,
    output logic             tx,
    output logic             busy
);

    import uart_pkg::*;

    localparam int IW = $clog2(WIDTH) + 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

    tx_state_t        r_state;
    tx_state_t        w_state_nx;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] w_sh_nx;
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    w_idx_nx;
    logic             r_par;
    logic             w_par_nx;
    logic             r_tx;
    logic             w_tx_nx;
    logic             w_pop;
    logic             w_clear;
    logic             w_bit_done;

    assign w_clear = (r_state == IDLE);

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_clear),
        .bit_done(w_bit_done)
    );

    always_comb begin
        w_state_nx = r_state;
        w_sh_nx    = r_sh;
        w_idx_nx   = r_idx;
        w_par_nx   = r_par;
        w_pop      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!fifo_empty) begin
                    w_pop      = 1'b1;
                    w_sh_nx    = fifo_rdata;
                    w_par_nx   = (PARITY == PAR_ODD) ? ~^fifo_rdata
                                                     : ^fifo_rdata;
                    w_state_nx = START;
                end
            end
            START: begin
                if (w_bit_done) begin
                    w_state_nx = DATA;
                    w_idx_nx   = '0;
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    w_sh_nx = r_sh >> 1;
                    if (r_idx == LAST_BIT) begin
                        w_state_nx = (PARITY != PAR_NONE) ? PAR : STOP;
                    end else begin
                        w_idx_nx = r_idx + IW'(1);
                    end
                end
            end
            PAR: begin
                if (w_bit_done) w_state_nx = STOP;
            end
            STOP: begin
                if (w_bit_done) w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Line level is chosen from the next state so tx stays a pure flop.
    always_comb begin
        w_tx_nx = 1'b1;
        unique case (w_state_nx)
            START:   w_tx_nx = 1'b0;
            DATA:    w_tx_nx = w_sh_nx[0];
            PAR:     w_tx_nx = w_par_nx;
            default: w_tx_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_idx   <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_sh    <= w_sh_nx;
            r_idx   <= w_idx_nx;
            r_par   <= w_par_nx;
            r_tx    <= w_tx_nx;
        end
    end

    assign fifo_read = w_pop & ~reset;
    assign tx        = r_tx;
    assign busy      = (r_state != IDLE);

endmodule
